// File: rtl/psum_accum_pkg.sv
// Shared types and helpers for the partial-sum accumulation bank.
// Build option: define ACC_SAT_EN for per-channel signed saturation
// (and the sticky sat_flag output); otherwise channels wrap modulo 2^bw.
package psum_accum_pkg;

    localparam int COL        = 8;
    localparam int PSUM_BW    = 16;
    localparam int PMEM_INDEX = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic              sat;
        logic signed [31:0] val;
    } add_res_t;

    // Operands arrive sign-extended to 32 bits; the result is brought back
    // into the bw-bit range either by wrapping or by clamping.
    function automatic add_res_t ch_add(input logic signed [31:0] a,
                                        input logic signed [31:0] b,
                                        input int bw);
        add_res_t           r;
        logic signed [31:0] s;
`ifdef ACC_SAT_EN
        logic signed [31:0] mx;
        logic signed [31:0] mn;
`endif
        s     = a + b;
        r.sat = 1'b0;
`ifdef ACC_SAT_EN
        mx = (32'sd1 <<< (bw - 1)) - 32'sd1;
        mn = -mx - 32'sd1;
        if (s > mx) begin
            r.val = mx;
            r.sat = 1'b1;
        end else if (s < mn) begin
            r.val = mn;
            r.sat = 1'b1;
        end else begin
            r.val = s;
        end
`else
        r.val = (s <<< (32 - bw)) >>> (32 - bw);
`endif
        return r;
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] v);
        return (v < 0) ? 32'sd0 : v;
    endfunction

endpackage

// File: rtl/psum_accum_lane.sv
// One channel of the bank: accumulate adder (wrap or saturate depending on
// ACC_SAT_EN) and the optional ReLU applied to readout data.
module psum_accum_lane
    import psum_accum_pkg::*;
#(
    parameter int BW = PSUM_BW
) (
    input  logic [BW-1:0] old_val,
    input  logic [BW-1:0] add_val,
    input  logic          first,
    input  logic [BW-1:0] rd_val,
    input  logic          relu_en,
    output logic [BW-1:0] sum,
    output logic          sat,
    output logic [BW-1:0] rd_out
);

    logic [BW-1:0]      base;
    logic signed [31:0] base_x;
    logic signed [31:0] add_x;
    logic signed [31:0] rd_x;
    logic signed [31:0] relu_x;
    add_res_t           res;
    logic               unused_hi;

    // First kij pass ignores the stored word; later passes add to it.
    always_comb begin
        base   = first ? '0 : old_val;
        base_x = 32'(signed'(base));
        add_x  = 32'(signed'(add_val));
        rd_x   = 32'(signed'(rd_val));
        res    = ch_add(base_x, add_x, BW);
        relu_x = relu(rd_x);
        sum    = res.val[BW-1:0];
        sat    = res.sat;
        rd_out = relu_en ? relu_x[BW-1:0] : rd_val;
    end

    assign unused_hi = ^{res.val[31:BW], relu_x[31:BW]};

endmodule

// File: rtl/sram.sv
// Simple one-read/one-write synchronous RAM. Read data is registered and
// read-during-write to the same word returns the old contents.
module sram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port share the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/psum_accum_bank.sv
// Partial-sum accumulation bank: 3-stage read-modify-write with forwarding,
// hardware bulk clear and a pipelined readout port.
// Build option: ACC_SAT_EN adds saturation and the sat_flag output.
//
// state | meaning
// IDLE  | one cycle after reset, nothing accepted
// RUN   | accumulate and readout traffic; clear waits for pipeline drain
// CLEAR | writes zero to every word, one per cycle, then back to RUN
module psum_accum_bank
    import psum_accum_pkg::*;
#(
    parameter int col        = COL,
    parameter int psum_bw    = PSUM_BW,
    parameter int pmem_index = PMEM_INDEX,
    parameter int pmem_depth = 1 << pmem_index
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_start,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic [pmem_index-1:0]     in_addr,
    input  logic [col*psum_bw-1:0]    in_data,
    input  logic                      rd_valid_in,
    output logic                      rd_ready,
    input  logic [pmem_index-1:0]     rd_addr,
    input  logic                      relu_en,
`ifdef ACC_SAT_EN
    output logic                      sat_flag,
`endif
    output logic                      rd_valid,
    output logic [col*psum_bw-1:0]    rd_data
);

    localparam int W = col * psum_bw;
    localparam logic [pmem_index-1:0] LAST_ADDR = pmem_index'(pmem_depth - 1);

    state_t                state_q, state_d;
    logic                  clear_pending_q, clear_pending_d;
    logic [pmem_index-1:0] clr_cnt_q, clr_cnt_d;
    logic                  acc_fire, rd_fire;

    logic                  v1, v2, v3, f1;
    logic [pmem_index-1:0] a1, a2, a3;
    logic [W-1:0]          d1, s2, s3;
    logic [W-1:0]          old_val, sum_val, relu_val;
    logic [col-1:0]        lane_sat;

    logic                  rv1, rr1;
    logic                  mem_we;
    logic [pmem_index-1:0] mem_waddr, mem_raddr;
    logic [W-1:0]          mem_wdata, mem_rdata;

    // State register, pending-clear latch and clear sweep down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            clear_pending_q <= 1'b0;
            clr_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            clr_cnt_q       <= clr_cnt_d;
        end
    end

    // Next state and handshake outputs; a clear waits until no op is in flight.
    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        clr_cnt_d       = clr_cnt_q;
        busy            = 1'b0;
        in_ready        = 1'b0;
        rd_ready        = 1'b0;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                in_ready = !clear_pending_q;
                rd_ready = !in_valid && !v1 && !v2;
                if (clear_start) begin
                    clear_pending_d = 1'b1;
                end
                if ((clear_pending_q || clear_start) &&
                    !(in_valid && !clear_pending_q) && !v1 && !v2) begin
                    state_d         = CLEAR;
                    clear_pending_d = 1'b0;
                    clr_cnt_d       = LAST_ADDR;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                clr_cnt_d = clr_cnt_q - 1'b1;
                if (clr_cnt_q == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_fire  = in_valid && in_ready;
    assign rd_fire   = rd_valid_in && rd_ready;
    assign mem_raddr = acc_fire ? in_addr : rd_addr;

    // Accumulate pipeline: stage1 holds the request, stage2 the sum being
    // written, stage3 the word written last cycle (still stale in the RAM read).
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= acc_fire;
            v2 <= v1;
            v3 <= v2;
        end
        a1 <= in_addr;
        d1 <= in_data;
        f1 <= in_first;
        a2 <= a1;
        s2 <= sum_val;
        a3 <= a2;
        s3 <= s2;
    end

    // Youngest in-flight sum to the same word overrides the RAM output.
    always_comb begin
        old_val = mem_rdata;
        if (v3 && (a3 == a1)) begin
            old_val = s3;
        end
        if (v2 && (a2 == a1)) begin
            old_val = s2;
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_accum_lane #(.BW(psum_bw)) u_lane (
            .old_val (old_val[c*psum_bw +: psum_bw]),
            .add_val (d1[c*psum_bw +: psum_bw]),
            .first   (f1),
            .rd_val  (mem_rdata[c*psum_bw +: psum_bw]),
            .relu_en (rr1),
            .sum     (sum_val[c*psum_bw +: psum_bw]),
            .sat     (lane_sat[c]),
            .rd_out  (relu_val[c*psum_bw +: psum_bw])
        );
    end

    // Write port: clear sweep or committed sum; nothing lands while in reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = a2;
        mem_wdata = s2;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = LAST_ADDR - clr_cnt_q;
                mem_wdata = '0;
            end else if (v2) begin
                mem_we = 1'b1;
            end
        end
    end

    sram #(.WIDTH(W), .DEPTH(pmem_depth), .AW(pmem_index)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Readout pipeline: accept, RAM read, registered (optionally ReLU'd) data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1      <= 1'b0;
            rr1      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rv1      <= rd_fire;
            rr1      <= relu_en;
            rd_valid <= rv1;
            if (rv1) begin
                rd_data <= relu_val;
            end
        end
    end

`ifdef ACC_SAT_EN
    // Sticky saturation indicator over committed sums.
    always_ff @(posedge clk) begin
        if (reset || clear_start) begin
            sat_flag <= 1'b0;
        end else if (v1 && (|lane_sat)) begin
            sat_flag <= 1'b1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^lane_sat;
`endif

endmodule
